// File: rtl/fir_pkg.sv
// Shared types and width helpers for the FIR filter family.
package fir_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int tree_width(input int in_width, input int n);
    return in_width + tree_levels(n);
  endfunction

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int LINK_MIN_WIDTH = 16 + 8;
  localparam int LINK_MAX_WIDTH = tree_width(LINK_MIN_WIDTH, 32 / 4);

endpackage

// File: rtl/fir_adder_tree.sv
// Combinational binary adder tree over 2^LEVELS signed inputs with a valid sideband.
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int IN_WIDTH = LINK_MIN_WIDTH,
  parameter int LEVELS   = tree_levels(32 / 4)
) (
  input  logic signed [IN_WIDTH-1:0]        data [2**LEVELS],
  input  logic                              valid_in,
  output logic signed [IN_WIDTH+LEVELS-1:0] sum,
  output logic                              valid_out
);

  localparam int N  = 1 << LEVELS;
  localparam int OW = IN_WIDTH + LEVELS;

  logic signed [OW-1:0] acc [N];

  // Every level is carried at the final width; a level of 2^l inputs cannot
  // exceed IN_WIDTH+l bits, so this matches a tree growing one bit per level.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc[i] = OW'(data[i]);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < (N >> (l + 1)); i++) begin
        acc[i] = acc[2*i] + acc[2*i+1];
      end
    end
    sum = acc[0];
  end

  assign valid_out = valid_in;

endmodule

// File: rtl/fir_interp_polyphase.sv
// Time-multiplexed polyphase interpolator: one multiplier bank shared across INTERP phases.
// state | meaning:  IDLE | waiting for a sample;  RUN | issuing phase k each cycle
module fir_interp_polyphase
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH = 16,
  parameter int COEFF_WIDTH = 8,
  parameter int INTERP      = 4,
  parameter int NUM_TAPS    = 32,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = '{default: COEFF_WIDTH'(1)},
  parameter int OUTPUT_WIDTH_FULL = INPUT_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS / INTERP),
  parameter int OUTPUT_WIDTH      = OUTPUT_WIDTH_FULL
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [INPUT_WIDTH-1:0]  din,
  input  logic                           valid_in,
  output logic                           ready_in,
  output logic signed [OUTPUT_WIDTH-1:0] dout,
  output logic                           valid_out,
  output logic [sel_width(INTERP)-1:0]   phase_out
);

  localparam int P      = NUM_TAPS / INTERP;
  localparam int LEVELS = tree_levels(P);
  localparam int NPAD   = 1 << LEVELS;
  localparam int PROD_W = INPUT_WIDTH + COEFF_WIDTH;
  localparam int SUM_W  = tree_width(PROD_W, P);
  localparam int PHW    = sel_width(INTERP);

  if (INTERP < 2) begin : g_bad_interp
    $error("fir_interp_polyphase: INTERP must be at least 2");
  end
  if ((NUM_TAPS % INTERP) != 0) begin : g_bad_taps
    $error("fir_interp_polyphase: NUM_TAPS must be a multiple of INTERP");
  end
  if (OUTPUT_WIDTH_FULL != SUM_W) begin : g_bad_full
    $error("fir_interp_polyphase: OUTPUT_WIDTH_FULL inconsistent with sum width");
  end

  state_t                         state;
  logic [PHW-1:0]                 phase;
  logic                           last_phase;
  logic                           accept;
  logic                           issue;
  logic signed [INPUT_WIDTH-1:0]  taps [P];
  logic signed [COEFF_WIDTH-1:0]  coef_tab [INTERP][P];
  logic signed [PROD_W-1:0]       prod_d [NPAD];
  logic signed [PROD_W-1:0]       prod_q [NPAD];
  logic                           prod_valid_q;
  logic [PHW-1:0]                 prod_phase_q;
  logic signed [SUM_W-1:0]        sum;
  logic                           sum_valid;
  logic signed [OUTPUT_WIDTH-1:0] dout_d;

  assign last_phase = (phase == PHW'(INTERP - 1));
  assign ready_in   = !rst && ((state == IDLE) || last_phase);
  assign accept     = valid_in && ready_in;
  assign issue      = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
    end else if (accept) begin
      state <= RUN;
      phase <= '0;
    end else if (state == RUN) begin
      if (last_phase) state <= IDLE;
      else            phase <= phase + PHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P; i++) taps[i] <= '0;
    end else if (accept) begin
      taps[0] <= din;
      for (int i = 1; i < P; i++) taps[i] <= taps[i-1];
    end
  end

  for (genvar k = 0; k < INTERP; k++) begin : g_phase
    for (genvar m = 0; m < P; m++) begin : g_tap
      assign coef_tab[k][m] = COEFFS[m*INTERP+k];
    end
  end

  // Unused tree leaves stay zero when P is not a power of two.
  always_comb begin
    for (int m = 0; m < NPAD; m++) prod_d[m] = '0;
    for (int m = 0; m < P; m++) begin
      prod_d[m] = PROD_W'(taps[m]) * PROD_W'(coef_tab[phase][m]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_valid_q <= 1'b0;
      prod_phase_q <= '0;
      for (int m = 0; m < NPAD; m++) prod_q[m] <= '0;
    end else begin
      prod_valid_q <= issue;
      prod_phase_q <= phase;
      if (issue) prod_q <= prod_d;
    end
  end

  fir_adder_tree #(
    .IN_WIDTH (PROD_W),
    .LEVELS   (LEVELS)
  ) u_tree (
    .data      (prod_q),
    .valid_in  (prod_valid_q),
    .sum       (sum),
    .valid_out (sum_valid)
  );

  if (OUTPUT_WIDTH <= SUM_W) begin : g_trunc
    assign dout_d = sum[SUM_W-1 -: OUTPUT_WIDTH];
    if (OUTPUT_WIDTH < SUM_W) begin : g_lsbs
      logic unused_lsbs;
      assign unused_lsbs = ^sum[SUM_W-OUTPUT_WIDTH-1:0];
    end
  end else begin : g_extend
    assign dout_d = OUTPUT_WIDTH'(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      valid_out <= 1'b0;
      phase_out <= '0;
    end else begin
      valid_out <= sum_valid;
      phase_out <= prod_phase_q;
      if (sum_valid) dout <= dout_d;
    end
  end

endmodule

// File: tb/tb_fir_interp_polyphase.sv
// Directed bench for fir_interp_polyphase: impulse, step, sparse, reset, extremes, truncation.
module tb_fir_interp_polyphase;

  localparam logic signed [7:0] C_RAMP [8] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
  localparam logic signed [7:0] C_NEG  [8] = '{default: -8'sd128};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [15:0] din_a, din_b, din_c;
  logic               valid_a, valid_b, valid_c;
  logic               ready_a, ready_b, ready_c;
  logic signed [24:0] dout_a, dout_b;
  logic signed [20:0] dout_c;
  logic               vo_a, vo_b, vo_c;
  logic [1:0]         ph_a, ph_b, ph_c;

  fir_interp_polyphase #(
    .INPUT_WIDTH(16), .COEFF_WIDTH(8), .INTERP(4), .NUM_TAPS(8), .COEFFS(C_RAMP),
    .OUTPUT_WIDTH_FULL(25), .OUTPUT_WIDTH(25)
  ) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .valid_in(valid_a), .ready_in(ready_a),
    .dout(dout_a), .valid_out(vo_a), .phase_out(ph_a)
  );

  fir_interp_polyphase #(
    .INPUT_WIDTH(16), .COEFF_WIDTH(8), .INTERP(4), .NUM_TAPS(8), .COEFFS(C_NEG),
    .OUTPUT_WIDTH_FULL(25), .OUTPUT_WIDTH(25)
  ) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .valid_in(valid_b), .ready_in(ready_b),
    .dout(dout_b), .valid_out(vo_b), .phase_out(ph_b)
  );

  fir_interp_polyphase #(
    .INPUT_WIDTH(16), .COEFF_WIDTH(8), .INTERP(4), .NUM_TAPS(8), .COEFFS(C_RAMP),
    .OUTPUT_WIDTH_FULL(25), .OUTPUT_WIDTH(21)
  ) dut_c (
    .clk(clk), .rst(rst), .din(din_c), .valid_in(valid_c), .ready_in(ready_c),
    .dout(dout_c), .valid_out(vo_c), .phase_out(ph_c)
  );

  typedef struct {
    int val;
    int ph;
    int cyc;
  } obs_t;

  obs_t qa[$], qb[$], qc[$];
  int   expv[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vo_a) qa.push_back('{int'(dout_a), int'(ph_a), cyc});
    if (vo_b) qb.push_back('{int'(dout_b), int'(ph_b), cyc});
    if (vo_c) qc.push_back('{int'(dout_c), int'(ph_c), cyc});
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready_a, 0);
    chk("rst_valid", vo_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_phase", ph_a, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    qa.delete(); qb.delete(); qc.delete();
  endtask

  task automatic send(input int sel, input int v, output int acc_cyc);
    logic rdy;
    int   n;
    case (sel)
      0: begin din_a = 16'(v); valid_a = 1'b1; end
      1: begin din_b = 16'(v); valid_b = 1'b1; end
      default: begin din_c = 16'(v); valid_c = 1'b1; end
    endcase
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;
      n++;
    end
    chk("ready_wait", rdy, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Output i of a run is phase i%4 and lands 2+i%4 cycles after its acceptance;
  // acceptances are 'gap' cycles apart.
  task automatic check_q(input int sel, input string tag, input int base, input int gap);
    obs_t q[$];
    case (sel)
      0: q = qa;
      1: q = qb;
      default: q = qc;
    endcase
    chk({tag, "_count"}, q.size(), expv.size());
    for (int i = 0; i < expv.size() && i < q.size(); i++) begin
      chk({tag, "_val"}, q[i].val, expv[i]);
      chk({tag, "_phase"}, q[i].ph, i % 4);
      chk({tag, "_cycle"}, q[i].cyc, base + 2 + (i / 4) * gap + (i % 4));
    end
  endtask

  initial begin
    int c0, t, rcnt;
    rst = 1'b1;
    din_a = '0; din_b = '0; din_c = '0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;

    // impulse
    do_reset();
    send(0, 1, c0);
    send(0, 0, t);
    send(0, 0, t);
    drain();
    expv.delete();
    for (int i = 1; i <= 8; i++) expv.push_back(i);
    for (int i = 0; i < 4; i++) expv.push_back(0);
    check_q(0, "impulse", c0, 4);

    // step with valid_in held high
    do_reset();
    din_a = 16'sd1;
    valid_a = 1'b1;
    c0 = cyc + 1;
    rcnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (ready_a) rcnt++;
    end
    valid_a = 1'b0;
    drain();
    chk("step_ready_count", rcnt, 6);
    expv.delete();
    for (int k = 0; k < 4; k++) expv.push_back(k + 1);
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 4; k++) expv.push_back(6 + 2 * k);
    check_q(0, "step", c0, 4);

    // sparse pulses, valid held through ready_in low
    do_reset();
    c0 = cyc + 1;
    for (int p = 0; p < 3; p++) begin
      din_a = 16'sd2;
      valid_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      valid_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    drain();
    expv.delete();
    for (int k = 0; k < 4; k++) expv.push_back(2 * (k + 1));
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) expv.push_back(12 + 4 * k);
    check_q(0, "sparse", c0, 6);

    // reset mid-burst
    do_reset();
    send(0, 1, c0);
    repeat (4) @(negedge clk);
    chk("midrst_pre_valid", vo_a, 1);
    chk("midrst_pre_phase", ph_a, 1);
    rst = 1'b1;
    #1;
    chk("midrst_ready_in_rst", ready_a, 0);
    @(negedge clk);
    chk("midrst_valid", vo_a, 0);
    chk("midrst_dout", dout_a, 0);
    chk("midrst_phase", ph_a, 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", ready_a, 1);
    @(negedge clk);
    chk("midrst_no_inflight", vo_a, 0);
    chk("midrst_flushed_count", qa.size(), 2);
    qa.delete();
    @(posedge clk);
    #1;
    send(0, 1, c0);
    send(0, 0, t);
    drain();
    expv.delete();
    for (int i = 1; i <= 8; i++) expv.push_back(i);
    check_q(0, "postrst", c0, 4);

    // extremes: -128 coefficients, -32768 input
    do_reset();
    din_b = -16'sd32768;
    valid_b = 1'b1;
    c0 = cyc + 1;
    repeat (16) @(posedge clk);
    #1;
    valid_b = 1'b0;
    drain();
    expv.delete();
    for (int i = 0; i < 4; i++) expv.push_back(4194304);
    for (int i = 0; i < 12; i++) expv.push_back(8388608);
    check_q(1, "extreme", c0, 4);

    // truncation: 4 LSBs dropped, impulse of 16
    do_reset();
    send(2, 16, c0);
    send(2, 0, t);
    send(2, 0, t);
    drain();
    expv.delete();
    for (int i = 1; i <= 8; i++) expv.push_back(i);
    for (int i = 0; i < 4; i++) expv.push_back(0);
    check_q(2, "trunc", c0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule
